// File: rtl/sr_flag_pkg.sv
// ---------------------------------------------------------------------------
// sr_flag_pkg
// Shared constants for the S-R flag arbiter: FSM state encodings, error
// codes and {s,r} command encodings.
// No ports (package).
// ---------------------------------------------------------------------------
package sr_flag_pkg;

   // FSM states
   localparam logic [0:0] ST_IDLE  = 1'b0;
   localparam logic [0:0] ST_APPLY = 1'b1;

   // Error codes reported on err_code
   localparam logic [1:0] ERR_NONE     = 2'b00;
   localparam logic [1:0] ERR_CONFLICT = 2'b01;
   localparam logic [1:0] ERR_RANGE    = 2'b10;

   // Command encodings, packed as {s, r}
   localparam logic [1:0] SR_HOLD  = 2'b00;
   localparam logic [1:0] SR_RESET = 2'b01;
   localparam logic [1:0] SR_SET   = 2'b10;
   localparam logic [1:0] SR_BOTH  = 2'b11;

endpackage

// File: rtl/sr_rr_arbiter.sv
// ---------------------------------------------------------------------------
// sr_rr_arbiter
// Combinational round-robin picker: grants the first requester at or after
// ptr_i, wrapping around. The pointer register lives in the parent.
// Ports:
//   req_i     in  NUM_REQ  request vector
//   ptr_i     in  PTR_W    highest-priority requester this cycle
//   en_i      in  1        when low no grant is produced
//   gnt_o     out NUM_REQ  one-hot grant
//   gnt_idx_o out PTR_W    index of the granted requester (0 if none)
// ---------------------------------------------------------------------------
module sr_rr_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int PTR_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
   input  logic [NUM_REQ-1:0] req_i,
   input  logic [PTR_W-1:0]   ptr_i,
   input  logic               en_i,
   output logic [NUM_REQ-1:0] gnt_o,
   output logic [PTR_W-1:0]   gnt_idx_o
);

   logic [PTR_W:0] pos;
   logic           found;

   always_comb begin
      gnt_o     = '0;
      gnt_idx_o = '0;
      found     = 1'b0;
      pos       = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         // ptr + k never exceeds 2*NUM_REQ-2, so one conditional subtract wraps it
         pos = {1'b0, ptr_i} + (PTR_W+1)'(k);
         if (pos >= (PTR_W+1)'(NUM_REQ)) pos = pos - (PTR_W+1)'(NUM_REQ);
         if (en_i && !found && req_i[pos[PTR_W-1:0]]) begin
            found            = 1'b1;
            gnt_o[pos[PTR_W-1:0]] = 1'b1;
            gnt_idx_o        = pos[PTR_W-1:0];
         end
      end
   end

endmodule

// File: rtl/sr_flag_arbiter.sv
// ---------------------------------------------------------------------------
// sr_flag_arbiter
// Bank of NUM_FLAGS S-R flags shared by NUM_REQ requesters. One command per
// valid/ready handshake, round-robin arbitration, two-state IDLE/APPLY
// sequencer (one command every two cycles). {s,r}=11 holds the flag and
// raises a conflict error; an out-of-range index raises a range error. Only
// the first error is kept until clr_all.
// Build option: SR_FLAG_TOGGLE_EN -- {s,r}=11 toggles the flag instead and
// never raises a conflict error.
// Ports:
//   clk, reset (async, active low), clr_all (sync clear)
//   req_valid/req_ready/req_s/req_r/req_idx  per-requester command channel
//   flag_q/flag_q_bar  flag bank outputs
//   busy, grant_id     sequencer status
//   err_valid/err_code/err_idx  sticky first-error record
// ---------------------------------------------------------------------------
module sr_flag_arbiter
   import sr_flag_pkg::*;
#(
   parameter int NUM_REQ   = 4,
   parameter int NUM_FLAGS = 8,
   parameter int IDX_W     = (NUM_FLAGS > 1) ? $clog2(NUM_FLAGS) : 1
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         clr_all,
   input  logic [NUM_REQ-1:0]           req_valid,
   output logic [NUM_REQ-1:0]           req_ready,
   input  logic [NUM_REQ-1:0]           req_s,
   input  logic [NUM_REQ-1:0]           req_r,
   input  logic [NUM_REQ*IDX_W-1:0]     req_idx,
   output logic [NUM_FLAGS-1:0]         flag_q,
   output logic [NUM_FLAGS-1:0]         flag_q_bar,
   output logic                         busy,
   output logic [$clog2(NUM_REQ)-1:0]   grant_id,
   output logic                         err_valid,
   output logic [1:0]                   err_code,
   output logic [IDX_W-1:0]             err_idx
);

   localparam int PTR_W = $clog2(NUM_REQ);
   // NUM_FLAGS widened by one bit so the range compare never truncates
   localparam logic [IDX_W:0] NF = (IDX_W+1)'(NUM_FLAGS);

   logic [0:0]           state_q, state_d;
   logic [PTR_W-1:0]     ptr_q, ptr_d;
   logic [PTR_W-1:0]     gid_q, gid_d;
   logic                 cs_q, cs_d, cr_q, cr_d;
   logic [IDX_W-1:0]     cidx_q, cidx_d;
   logic [NUM_FLAGS-1:0] flags_q, flags_d;
   logic                 errv_q, errv_d;
   logic [1:0]           ecode_q, ecode_d;
   logic [IDX_W-1:0]     eidx_q, eidx_d;

   logic [NUM_REQ-1:0]   gnt;
   logic [PTR_W-1:0]     gnt_idx;
   logic                 arb_en;
   logic                 hs;

   // No grants outside IDLE or while the bank is being cleared
   assign arb_en = (state_q == ST_IDLE) && !clr_all;

   sr_rr_arbiter #(
      .NUM_REQ (NUM_REQ),
      .PTR_W   (PTR_W)
   ) u_arb (
      .req_i     (req_valid),
      .ptr_i     (ptr_q),
      .en_i      (arb_en),
      .gnt_o     (gnt),
      .gnt_idx_o (gnt_idx)
   );

   assign req_ready = gnt;
   assign hs        = |(req_valid & gnt);

   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      gid_d   = gid_q;
      cs_d    = cs_q;
      cr_d    = cr_q;
      cidx_d  = cidx_q;
      flags_d = flags_q;
      errv_d  = errv_q;
      ecode_d = ecode_q;
      eidx_d  = eidx_q;

      if (clr_all) begin
         // Pending APPLY is dropped; pointer and last grant id are kept
         state_d = ST_IDLE;
         flags_d = '0;
         errv_d  = 1'b0;
         ecode_d = ERR_NONE;
         eidx_d  = '0;
      end else if (state_q == ST_IDLE) begin
         if (hs) begin
            cs_d    = req_s[gnt_idx];
            cr_d    = req_r[gnt_idx];
            cidx_d  = req_idx[gnt_idx*IDX_W +: IDX_W];
            gid_d   = gnt_idx;
            ptr_d   = (gnt_idx == PTR_W'(NUM_REQ-1)) ? '0 : gnt_idx + 1'b1;
            state_d = ST_APPLY;
         end
      end else begin
         state_d = ST_IDLE;
         if ({1'b0, cidx_q} >= NF) begin
            if (!errv_q) begin
               errv_d  = 1'b1;
               ecode_d = ERR_RANGE;
               eidx_d  = cidx_q;
            end
         end else begin
            case ({cs_q, cr_q})
               SR_RESET: flags_d[cidx_q] = 1'b0;
               SR_SET:   flags_d[cidx_q] = 1'b1;
               SR_BOTH: begin
`ifdef SR_FLAG_TOGGLE_EN
                  flags_d[cidx_q] = ~flags_q[cidx_q];
`else
                  if (!errv_q) begin
                     errv_d  = 1'b1;
                     ecode_d = ERR_CONFLICT;
                     eidx_d  = cidx_q;
                  end
`endif
               end
               default: ; // hold: command consumed, flag untouched
            endcase
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= ST_IDLE;
         ptr_q   <= '0;
         gid_q   <= '0;
         cs_q    <= 1'b0;
         cr_q    <= 1'b0;
         cidx_q  <= '0;
         flags_q <= '0;
         errv_q  <= 1'b0;
         ecode_q <= ERR_NONE;
         eidx_q  <= '0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         gid_q   <= gid_d;
         cs_q    <= cs_d;
         cr_q    <= cr_d;
         cidx_q  <= cidx_d;
         flags_q <= flags_d;
         errv_q  <= errv_d;
         ecode_q <= ecode_d;
         eidx_q  <= eidx_d;
      end
   end

   assign flag_q     = flags_q;
   assign flag_q_bar = ~flags_q;
   assign busy       = (state_q == ST_APPLY);
   assign grant_id   = gid_q;
   assign err_valid  = errv_q;
   assign err_code   = ecode_q;
   assign err_idx    = eidx_q;

endmodule

// File: tb/tb_sr_flag_arbiter.sv
// ---------------------------------------------------------------------------
// tb_sr_flag_arbiter
// Directed bench for sr_flag_arbiter with NUM_REQ=4, NUM_FLAGS=6 (IDX_W=3),
// so indices 6 and 7 exercise the range error. Inputs change 1 ns after the
// rising edge; outputs are sampled on the falling edge or 1 ns after rising.
// ---------------------------------------------------------------------------
module tb_sr_flag_arbiter;

   localparam int NR = 4;
   localparam int NF = 6;
   localparam int IW = 3;

   logic          clk = 1'b0;
   logic          reset;
   logic          clr_all;
   logic [NR-1:0] req_valid, req_s, req_r;
   logic [NR*IW-1:0] req_idx;
   logic [NR-1:0] req_ready;
   logic [NF-1:0] flag_q, flag_q_bar;
   logic          busy;
   logic [1:0]    grant_id;
   logic          err_valid;
   logic [1:0]    err_code;
   logic [IW-1:0] err_idx;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   sr_flag_arbiter #(.NUM_REQ(NR), .NUM_FLAGS(NF), .IDX_W(IW)) dut (
      .clk        (clk),
      .reset      (reset),
      .clr_all    (clr_all),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_s      (req_s),
      .req_r      (req_r),
      .req_idx    (req_idx),
      .flag_q     (flag_q),
      .flag_q_bar (flag_q_bar),
      .busy       (busy),
      .grant_id   (grant_id),
      .err_valid  (err_valid),
      .err_code   (err_code),
      .err_idx    (err_idx)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic to_neg();
      @(negedge clk);
   endtask

   task automatic to_pos();
      @(posedge clk);
      #1;
   endtask

   // One full command from requester id; returns 1 ns after the APPLY edge.
   task automatic send(input int id, input logic s, input logic r,
                       input logic [IW-1:0] idx, input logic [NR-1:0] exp_rdy);
      req_valid = '0;
      req_valid[id] = 1'b1;
      req_s[id] = s;
      req_r[id] = r;
      req_idx[id*IW +: IW] = idx;
      to_neg();
      chk("ready", req_ready, exp_rdy);
      to_pos();
      req_valid = '0;
      to_neg();
      chk("busy_apply", busy, 1'b1);
      chk("grant_id", grant_id, id);
      chk("ready_apply", req_ready, '0);
      to_pos();
   endtask

   task automatic chk_err(input logic v, input logic [1:0] c, input logic [IW-1:0] i);
      chk("err_valid", err_valid, v);
      chk("err_code", err_code, c);
      chk("err_idx", err_idx, i);
   endtask

   initial begin
      reset = 1'b0; clr_all = 1'b0;
      req_valid = '0; req_s = '0; req_r = '0; req_idx = '0;

      // Reset values, asserted before any clock edge
      #2;
      chk("rst_flag_q", flag_q, 6'h00);
      chk("rst_flag_q_bar", flag_q_bar, 6'h3F);
      chk("rst_busy", busy, 1'b0);
      chk("rst_ready", req_ready, 4'b0000);
      chk("rst_grant_id", grant_id, 2'd0);
      chk_err(1'b0, 2'b00, 3'd0);
      #10 reset = 1'b1;
      to_pos();

      // Basic set / reset of flag 3
      send(0, 1'b1, 1'b0, 3'd3, 4'b0001);
      chk("set3", flag_q, 6'h08);
      chk("set3_bar", flag_q_bar, 6'h37);
      chk("busy_idle", busy, 1'b0);
      send(1, 1'b0, 1'b1, 3'd3, 4'b0010);
      chk("reset3", flag_q, 6'h00);

      // Round robin: all valid, each sets its own index; pointer is now 2
      // so rotation starts at 2: order 2,3,0,1
      req_valid = 4'b1111; req_s = 4'b1111; req_r = 4'b0000;
      req_idx = {3'd3, 3'd2, 3'd1, 3'd0};
      for (int k = 0; k < 4; k++) begin
         to_neg();
         chk("rr_ready", req_ready, 4'b0001 << ((k + 2) % 4));
         chk("rr_busy_idle", busy, 1'b0);
         to_pos();
         req_valid[(k + 2) % 4] = 1'b0;
         to_neg();
         chk("rr_busy_apply", busy, 1'b1);
         chk("rr_ready_apply", req_ready, 4'b0000);
         chk("rr_grant_id", grant_id, (k + 2) % 4);
         to_pos();
      end
      chk("rr_flags", flag_q, 6'h0F);

      // Pointer now 2. Set flag 5, then S=R=1 commands
      send(2, 1'b1, 1'b0, 3'd5, 4'b0100);
      chk("set5", flag_q, 6'h2F);
`ifdef SR_FLAG_TOGGLE_EN
      send(3, 1'b1, 1'b1, 3'd5, 4'b1000);
      chk("toggle5_a", flag_q, 6'h0F);
      chk("toggle_no_err", err_valid, 1'b0);
      send(0, 1'b1, 1'b1, 3'd5, 4'b0001);
      chk("toggle5_b", flag_q, 6'h2F);
      chk_err(1'b0, 2'b00, 3'd0);
`else
      send(3, 1'b1, 1'b1, 3'd5, 4'b1000);
      chk("conflict_hold", flag_q, 6'h2F);
      chk_err(1'b1, 2'b01, 3'd5);
      send(0, 1'b1, 1'b1, 3'd2, 4'b0001);
      chk("conflict2_hold", flag_q, 6'h2F);
      chk_err(1'b1, 2'b01, 3'd5);
`endif

      // clr_all during APPLY; pointer is 1 here
      req_valid = 4'b0010; req_s[1] = 1'b1; req_r[1] = 1'b0; req_idx[1*IW +: IW] = 3'd1;
      to_neg();
      chk("clr_ready", req_ready, 4'b0010);
      to_pos();
      req_valid = '0;
      clr_all = 1'b1;
      to_neg();
      chk("clr_busy", busy, 1'b1);
      to_pos();
      chk("clr_flags", flag_q, 6'h00);
      chk("clr_busy_after", busy, 1'b0);
      chk_err(1'b0, 2'b00, 3'd0);
      // clr_all still high: valid requesters see no ready
      req_valid = 4'b1001;
      to_neg();
      chk("clr_force_ready0", req_ready, 4'b0000);
      clr_all = 1'b0;
      #1;
      // Pointer preserved at 2: first valid at/after 2 is requester 3
      chk("ptr_preserved", req_ready, 4'b1000);
      req_valid = '0;
      to_pos();
      chk("clr_no_capture", busy, 1'b0);

      // Range errors (pointer still 2); flag 0 set first
      send(0, 1'b1, 1'b0, 3'd0, 4'b0001);
      chk("set0", flag_q, 6'h01);
      send(1, 1'b1, 1'b0, 3'd7, 4'b0010);
      chk("range7_flags", flag_q, 6'h01);
      chk_err(1'b1, 2'b10, 3'd7);
      send(2, 1'b1, 1'b0, 3'd6, 4'b0100);
      chk("range6_flags", flag_q, 6'h01);
      chk_err(1'b1, 2'b10, 3'd7);
      // Error does not stall: next command still applied
      send(3, 1'b0, 1'b1, 3'd0, 4'b1000);
      chk("after_err", flag_q, 6'h00);
      send(0, 1'b0, 1'b0, 3'd4, 4'b0001);
      chk("hold_cmd", flag_q, 6'h00);

      // Reset in the middle of APPLY drops the captured command
      send(2, 1'b1, 1'b0, 3'd4, 4'b0100);
      chk("set4", flag_q, 6'h10);
      req_valid = 4'b0100; req_s[2] = 1'b1; req_idx[2*IW +: IW] = 3'd2;
      to_pos();
      req_valid = '0;
      #2 reset = 1'b0;
      #1;
      chk("mid_rst_busy", busy, 1'b0);
      chk("mid_rst_flags", flag_q, 6'h00);
      chk("mid_rst_gid", grant_id, 2'd0);
      chk_err(1'b0, 2'b00, 3'd0);
      reset = 1'b1;
      to_pos();
      to_pos();
      chk("mid_rst_lost", flag_q, 6'h00);
      chk("mid_rst_bar", flag_q_bar, 6'h3F);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/sr_flag_arbiter.md
Name: sr_flag_arbiter

Overview:
- Shares a bank of NUM_FLAGS S-R flag flip-flops between NUM_REQ requesters.
- Each requester issues one set/reset command per valid/ready handshake. The block arbitrates round-robin, sequences the update, and owns every flag's q/q_bar.
- Defines the S=R=1 case (error, flag held) instead of driving X.
- Sits between control agents and any logic that consumes the flag bank.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- NUM_FLAGS, 8, number of S-R flags (1..64).
- IDX_W, $clog2(NUM_FLAGS) (min 1), width of the flag index field.

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- clr_all  in  1  synchronous clear of all flags and error state.
- req_valid  in  NUM_REQ  per-requester command valid.
- req_ready  out  NUM_REQ  per-requester accept, at most one bit high.
- req_s  in  NUM_REQ  per-requester S bit.
- req_r  in  NUM_REQ  per-requester R bit.
- req_idx  in  NUM_REQ*IDX_W  per-requester flag index, requester i at bits [i*IDX_W +: IDX_W].
- flag_q  out  NUM_FLAGS  flag outputs.
- flag_q_bar  out  NUM_FLAGS  always ~flag_q.
- busy  out  1  high while in APPLY.
- grant_id  out  $clog2(NUM_REQ)  requester captured for the current or last APPLY.
- err_valid  out  1  sticky error flag.
- err_code  out  2  01 = S/R conflict, 10 = index out of range.
- err_idx  out  IDX_W  flag index of the first error.

Behaviour:
- Reset (reset low, asynchronous):
  - state = IDLE; req_ready = 0; busy = 0; grant_id = 0.
  - flag_q = 0; flag_q_bar = all ones.
  - err_valid = 0; err_code = 0; err_idx = 0.
  - round-robin pointer = 0.
- IDLE state:
  - req_ready is combinational: one-hot to the first valid requester at or after the pointer, wrapping.
  - A handshake (valid & ready) captures s, r, idx and the winner id, then moves to APPLY.
  - Pointer becomes winner+1 mod NUM_REQ.
  - No valid request: stay in IDLE, pointer unchanged.
- APPLY state (one cycle):
  - req_ready = 0, busy = 1.
  - The update below is applied at the closing edge, then the state returns to IDLE.
  - Update rules:
    - {s,r} = 00: hold; the command is still consumed.
    - {s,r} = 01: flag = 0.
    - {s,r} = 10: flag = 1.
    - {s,r} = 11: flag held; conflict error.
    - idx >= NUM_FLAGS: no flag changes; range error.
- Latency and throughput:
  - Handshake in cycle T; flag_q is updated and visible in T+2.
  - One command per 2 cycles. A requester is re-granted no earlier than T+2.
- Handshake rules:
  - A requester holds valid, s, r and idx stable until ready.
  - Deasserting valid before ready is allowed; nothing is captured.
- Errors:
  - Only the first error is recorded. It sets err_valid and loads err_code and err_idx; later errors do not overwrite it.
  - An error does not stall arbitration.
- clr_all (synchronous, highest priority after reset):
  - In that cycle: flags = 0, err_valid, err_code and err_idx cleared, req_ready forced 0.
  - A pending APPLY is discarded; state = IDLE.
  - The pointer is preserved.
- Fairness: with all requesters valid, grants rotate 0,1,2,3,0 and so on. No requester waits more than NUM_REQ grants.
- Reset mid-APPLY: the captured command is lost and all outputs return to their reset values immediately.

Optional Feature:
- Macro: SR_FLAG_TOGGLE_EN.
- Defined: {s,r} = 11 toggles the flag (JK behaviour) and raises no conflict error. err_code 01 is never produced.
- Undefined: behaviour exactly as specified above.

Decomposition:
- Package sr_flag_pkg:
  - state enum {IDLE, APPLY}.
  - err_code constants ERR_NONE = 00, ERR_CONFLICT = 01, ERR_RANGE = 10.
  - S/R command encodings.
- Sub-module sr_rr_arbiter:
  - Parameterised NUM_REQ.
  - Inputs: req vector, pointer, enable.
  - Outputs: one-hot grant and grant index.
  - Purely combinational; the pointer register stays in the parent.

Test Plan:
- Reset/basic:
  - Reset low, then high; check flag_q = 0x00, flag_q_bar = 0xFF.
  - Requester 0 sends s=1, r=0, idx=3: ready in T, flag_q = 0x08 in T+2.
  - Then s=0, r=1, idx=3: flag_q = 0x00.
- Round-robin: all 4 requesters valid, each setting idx = its own id. Grant order is 0,1,2,3 on alternate cycles; flag_q = 0x0F after 8 cycles; busy toggles every cycle.
- Conflict: flag 5 set, then s=1, r=1, idx=5. flag_q[5] stays 1; err_valid = 1, err_code = 01, err_idx = 5. A later conflict on idx 2 leaves err_idx = 5.
- Range: NUM_FLAGS = 6, command idx = 7, s=1. No flag changes; err_code = 10, err_idx = 7.
- clr_all during APPLY: command s=1, idx=1 captured, clr_all asserted in its APPLY cycle. flag_q = 0, error cleared, state IDLE, req_ready = 0 that cycle.
- Toggle build (SR_FLAG_TOGGLE_EN defined): two successive s=1, r=1, idx=0 commands give flag_q[0] = 1, then 0; err_valid stays 0.
